// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel-enable divider, raster counters, a
// delay line that aligns sync/de with an external pixel source, and colour bars.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk50MHz,
  input  logic          reset,
  input  logic          pattern_en,
  input  logic [CW-1:0] red_in,
  input  logic [CW-1:0] green_in,
  input  logic [CW-1:0] blue_in,
  output logic          pix_ce,
  output logic          pix_clk,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [XW-1:0] BAR_WX = XW'(BAR_W);

  // Everything the output stage needs about one pixel, including its frame's mode.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       pat;
    logic [2:0] bar;
  } bundle_t;

  localparam bundle_t IDLE = '0;

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [XW-1:0] hcount;
  logic [YW-1:0] vcount;
  logic [XW-1:0] bar_q;
  logic          mode;
  bundle_t       s0;
  bundle_t       dly;

  assign div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
  assign pix_ce  = (div == DIV_LAST);

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      div     <= '0;
      pix_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      pix_clk <= (div_nxt < DIV_HALF);
    end
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + YW'(1);
      end else begin
        hcount <= hcount + XW'(1);
      end
    end
  end

  assign x           = hcount;
  assign y           = vcount;
  assign active      = (hcount < H_ACT) && (vcount < V_ACT);
  assign frame_start = pix_ce && (hcount == '0) && (vcount == '0);

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset)            mode <= 1'b0;
    else if (frame_start) mode <= pattern_en;
  end

  // The (0,0) pixel already belongs to the new frame, so it sees pattern_en directly.
  always_comb begin
    bar_q  = hcount / BAR_WX;
    s0.hs  = (hcount >= HS_BEG) && (hcount <= HS_END);
    s0.vs  = (vcount >= VS_BEG) && (vcount <= VS_END);
    s0.act = active;
    s0.pat = frame_start ? pattern_en : mode;
    s0.bar = (bar_q > XW'(7)) ? 3'd7 : bar_q[2:0];
  end

  generate
    if (PIPE_DLY == 0) begin : g_bypass
      assign dly = s0;
    end else begin : g_pipe
      bundle_t stage [PIPE_DLY];
      always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) stage[i] <= IDLE;
        end else if (pix_ce) begin
          stage[0] <= s0;
          for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly = stage[PIPE_DLY-1];
    end
  endgenerate

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_ce) begin
      hsync <= dly.hs ? HS_POL : ~HS_POL;
      vsync <= dly.vs ? VS_POL : ~VS_POL;
      de    <= dly.act;
      if (!dly.act) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (dly.pat) begin
        red   <= {CW{dly.bar[2]}};
        green <= {CW{dly.bar[1]}};
        blue  <= {CW{dly.bar[0]}};
      end else begin
        red   <= red_in;
        green <= green_in;
        blue  <= blue_in;
      end
    end
  end

endmodule
